// File: rtl/alu_pkg.sv
// Shared encodings for the calculator ALU sequencer: op codes, FSM states, default width.
package alu_pkg;
  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_DONE  = 2'b10
  } state_t;
endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request/response bundle between the parser/consumer (master) and the sequencer (slave).
// Optional rsp_ovf exists only when ALU_OVF_FLAG_EN is defined.
interface alu_seq_ctrl_if
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // the sender holds valid and payload stable until that edge, ready may change freely.
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [1:0]       req_op;
  logic             req_chain;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_err;
`ifdef ALU_OVF_FLAG_EN
  logic             rsp_ovf;
`endif

  modport master (
    output req_valid, req_a, req_b, req_op, req_chain, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_err
`ifdef ALU_OVF_FLAG_EN
    , input rsp_ovf
`endif
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_chain, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_err
`ifdef ALU_OVF_FLAG_EN
    , output rsp_ovf
`endif
  );
endinterface

// File: rtl/alu_ovf_chk.sv
// Full-width overflow/borrow detection for the ALU operands (used with ALU_OVF_FLAG_EN).
module alu_ovf_chk
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             ovf
);
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  always_comb begin
    ovf = 1'b0;
    case (op)
      OP_ADD:  ovf = sum[WIDTH];
      OP_SUB:  ovf = (a < b);
      OP_MUL:  ovf = |prod[2*WIDTH-1:WIDTH];
      default: ovf = 1'b0;
    endcase
  end
endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer in front of the calculator ALU: registers operands, captures the result, keeps a
// chainable accumulator and traps divide-by-zero. ALU_OVF_FLAG_EN adds the rsp_ovf flag.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int               WIDTH    = DEF_WIDTH,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  alu_seq_ctrl_if.slave    bus,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] acc_value,
  output logic             busy,
  output state_t           state_dbg
);
  state_t state;
  logic   div_zero;

  assign div_zero      = (bus.req_op == OP_DIV) && (bus.req_b == '0);
  assign bus.req_ready = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign state_dbg     = state;

`ifdef ALU_OVF_FLAG_EN
  logic ovf_c;

  alu_ovf_chk #(.WIDTH(WIDTH)) u_ovf_chk (
    .a   (alu_a),
    .b   (alu_b),
    .op  (alu_op),
    .ovf (ovf_c)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_op         <= 2'b00;
      acc_value      <= ACC_INIT;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_err    <= 1'b0;
`ifdef ALU_OVF_FLAG_EN
      bus.rsp_ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            alu_a  <= bus.req_chain ? acc_value : bus.req_a;
            alu_b  <= bus.req_b;
            alu_op <= bus.req_op;
            if (div_zero) begin
              // Trap without an ALU pass: respond on the next edge, accumulator untouched.
              bus.rsp_valid  <= 1'b1;
              bus.rsp_result <= '0;
              bus.rsp_err    <= 1'b1;
`ifdef ALU_OVF_FLAG_EN
              bus.rsp_ovf    <= 1'b0;
`endif
              state          <= ST_DONE;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          bus.rsp_valid  <= 1'b1;
          bus.rsp_result <= alu_result;
          bus.rsp_err    <= 1'b0;
`ifdef ALU_OVF_FLAG_EN
          bus.rsp_ovf    <= ovf_c;
`endif
          acc_value      <= alu_result;
          state          <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // Placed last so a clear beats an ISSUE capture into the accumulator.
      if (acc_clr) acc_value <= ACC_INIT;
    end
  end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl with a behavioural 4-bit ALU and a result scoreboard.
module tb_alu_seq_ctrl;
  import alu_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         acc_clr;
  logic [W-1:0] alu_a, alu_b, alu_result, acc_value;
  logic [1:0]   alu_op;
  logic         busy;
  state_t       state_dbg;

  alu_seq_ctrl_if #(.WIDTH(W)) bus ();

  alu_seq_ctrl #(.WIDTH(W), .ACC_INIT('0)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .acc_clr    (acc_clr),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .acc_value  (acc_value),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // Behavioural ALU sitting beside the controller.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      2'b00: alu_result = alu_a + alu_b;
      2'b01: alu_result = alu_a - alu_b;
      2'b10: alu_result = alu_a * alu_b;
      default: alu_result = (alu_b == '0) ? '0 : alu_a / alu_b;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_err_q[$];
  logic         exp_ovf_q[$];
  logic [W-1:0] model_acc;

  task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                        input logic chain, input logic clr_cap, input int hold);
    int           ea, eb, er, waited, lat;
    logic         ee, eo, dz;
    logic [W-1:0] eff_a, got_r, rsp_snap;
    logic         got_e, got_o;
    waited = 0;
    while (!bus.req_ready && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    n_cmp++;
    if (waited >= 20) begin n_fail++; $display("FAIL req_ready_wait: req_ready=%b required 1", bus.req_ready); end
    eff_a = chain ? model_acc : a;
    ea = int'(eff_a); eb = int'(b);
    dz = (op == 2'b11) && (b == '0);
    ee = dz; eo = 1'b0; er = 0;
    case (op)
      2'b00: begin er = (ea + eb) % 16; eo = (ea + eb) > 15; end
      2'b01: begin er = (ea - eb + 16) % 16; eo = ea < eb; end
      2'b10: begin er = (ea * eb) % 16; eo = (ea * eb) > 15; end
      default: er = dz ? 0 : ea / eb;
    endcase
    exp_q.push_back(W'(er)); exp_err_q.push_back(ee); exp_ovf_q.push_back(eo);
    bus.req_valid = 1'b1; bus.req_a = a; bus.req_b = b; bus.req_op = op; bus.req_chain = chain;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    n_cmp++;
    if (alu_a !== eff_a || alu_b !== b || alu_op !== op) begin
      n_fail++; $display("FAIL alu_regs: a=%h b=%h op=%b required a=%h b=%h op=%b", alu_a, alu_b, alu_op, eff_a, b, op);
    end
    if (clr_cap && !dz) acc_clr = 1'b1;
    while (!bus.rsp_valid && lat < 10) begin
      @(posedge clk); #1; lat++; acc_clr = 1'b0;
    end
    acc_clr = 1'b0;
    n_cmp++;
    if (lat !== (dz ? 1 : 2)) begin n_fail++; $display("FAIL latency: %0d edges required %0d", lat, dz ? 1 : 2); end
    got_r = exp_q.pop_front(); got_e = exp_err_q.pop_front(); got_o = exp_ovf_q.pop_front();
    n_cmp++;
    if (bus.rsp_result !== got_r || bus.rsp_err !== got_e) begin
      n_fail++; $display("FAIL rsp_fields: result=%h err=%b required result=%h err=%b", bus.rsp_result, bus.rsp_err, got_r, got_e);
    end
`ifdef ALU_OVF_FLAG_EN
    n_cmp++;
    if (bus.rsp_ovf !== got_o) begin n_fail++; $display("FAIL rsp_ovf: %b required %b", bus.rsp_ovf, got_o); end
`endif
    if (!got_e) model_acc = clr_cap ? '0 : got_r;
    n_cmp++;
    if (acc_value !== model_acc) begin n_fail++; $display("FAIL acc_value: %h required %h", acc_value, model_acc); end
    rsp_snap = bus.rsp_result;
    repeat (hold) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== rsp_snap || bus.req_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL backpressure: valid=%b result=%h req_ready=%b busy=%b required 1/%h/0/1", bus.rsp_valid, bus.rsp_result, bus.req_ready, busy, rsp_snap);
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    n_cmp++;
    if (bus.rsp_valid !== 1'b0 || state_dbg !== ST_IDLE || bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL release: valid=%b state=%0d req_ready=%b required 0/%0d/1", bus.rsp_valid, state_dbg, bus.req_ready, ST_IDLE);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    n_cmp++;
    if (alu_a !== '0 || alu_b !== '0 || alu_op !== 2'b00 || bus.rsp_result !== '0 ||
        bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || acc_value !== '0 ||
        busy !== 1'b0 || bus.req_ready !== 1'b1 || state_dbg !== ST_IDLE) begin
      n_fail++;
      $display("FAIL %s: a=%h b=%h op=%b res=%h v=%b e=%b acc=%h busy=%b rdy=%b st=%0d required all 0 except rdy=1",
               tag, alu_a, alu_b, alu_op, bus.rsp_result, bus.rsp_valid, bus.rsp_err, acc_value, busy, bus.req_ready, state_dbg);
    end
`ifdef ALU_OVF_FLAG_EN
    n_cmp++;
    if (bus.rsp_ovf !== 1'b0) begin n_fail++; $display("FAIL %s_ovf: %b required 0", tag, bus.rsp_ovf); end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    model_acc = '0;
  endtask

  task automatic test_basic();
    do_req(4'd3, 4'd4, 2'b00, 1'b0, 1'b0, 0);
  endtask

  task automatic test_chain();
    do_req(4'd0, 4'd2, 2'b10, 1'b1, 1'b0, 0);
  endtask

  task automatic test_div_zero();
    do_req(4'd9, 4'd0, 2'b11, 1'b0, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    do_req(4'd6, 4'd2, 2'b11, 1'b0, 1'b0, 5);
  endtask

  task automatic test_wrap_ovf();
    do_req(4'd2, 4'd5, 2'b01, 1'b0, 1'b0, 0);
    do_req(4'd15, 4'd1, 2'b00, 1'b0, 1'b0, 0);
    do_req(4'd5, 4'd4, 2'b10, 1'b0, 1'b0, 1);
  endtask

  task automatic test_acc_clr();
    do_req(4'd5, 4'd3, 2'b00, 1'b0, 1'b1, 0);
  endtask

  task automatic test_rst_mid();
    bus.req_valid = 1'b1; bus.req_a = 4'd7; bus.req_b = 4'd3; bus.req_op = 2'b00; bus.req_chain = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n_cmp++;
    if (state_dbg !== ST_ISSUE) begin n_fail++; $display("FAIL rst_mid_state: %0d required %0d", state_dbg, ST_ISSUE); end
    rst = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    model_acc = '0;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_dropped: rsp_valid=%b required 0", bus.rsp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    logic [1:0]   op;
    logic         ch;
    for (int i = 0; i < 10; i++) begin
      a  = W'($urandom_range(0, 15));
      b  = (i % 4 == 3) ? '0 : W'($urandom_range(0, 15));
      op = 2'($urandom_range(0, 3));
      ch = 1'($urandom_range(0, 1));
      do_req(a, b, op, ch, 1'b0, $urandom_range(0, 2));
    end
  endtask

  initial begin
    rst = 1'b1; acc_clr = 1'b0;
    bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_op = 2'b00;
    bus.req_chain = 1'b0; bus.rsp_ready = 1'b0;
    model_acc = '0;
    test_reset();
    test_basic();
    test_chain();
    test_div_zero();
    test_backpressure();
    test_wrap_ovf();
    test_acc_clr();
    test_rst_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
